// File: rtl/level_4_merge.sv
// level_4_merge
//   Level-4 stage of the merge-sort tree. A 32-element frame holds four
//   ascending 8-element runs (R0..R3). Two lanes merge them serially, one
//   element per lane per cycle, over 16 cycles:
//     lane A = merge(R0, R1) -> odata elements 0..15
//     lane B = merge(R2, R3) -> odata elements 16..31
//   Each lane pops the larger head and shifts it in at the bottom of its
//   half. After 16 pops the largest element is at the top index, so each
//   half comes out ascending by index.
//
// Configuration macro:
//   MERGE_L4_SIGNED_EN  defined   -> heads compared as two's-complement
//                       undefined -> heads compared as unsigned
//
// Ports:
//   clk     in   1              rising-edge clock
//   rst     in   1              asynchronous active-high reset
//   idata   in   32*DATA_WIDTH  input runs, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ivalid  in   1              frame present, taken when iready=1
//   iready  out  1              high while idle
//   odata   out  32*DATA_WIDTH  two merged 16-element runs
//   ovalid  out  1              one-cycle pulse marking odata valid
module level_4_merge #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [32*DATA_WIDTH-1:0]   idata,
    input  logic                       ivalid,
    output logic                       iready,
    output logic [32*DATA_WIDTH-1:0]   odata,
    output logic                       ovalid
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MERGE = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [DATA_WIDTH-1:0]     r_run [4][8];
    logic [3:0]                r_pop [4];
    logic [3:0]                r_cnt;
    logic [16*DATA_WIDTH-1:0]  r_lane_a;
    logic [16*DATA_WIDTH-1:0]  r_lane_b;
    logic                      r_ovalid;

    logic [DATA_WIDTH-1:0]     w_head [4];
    logic                      w_exh  [4];
    logic                      w_sel_r1;
    logic                      w_sel_r3;
    logic [DATA_WIDTH-1:0]     w_pick_a;
    logic [DATA_WIDTH-1:0]     w_pick_b;
    logic                      w_accept;
    logic                      w_last;

    // Returns 1 when a >= b under the configured ordering.
    function automatic logic head_ge(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
`ifdef MERGE_L4_SIGNED_EN
        return ($signed(a) >= $signed(b));
`else
        return (a >= b);
`endif
    endfunction

    // Head of each run is the highest unpopped index (7 - pops). When a run
    // is exhausted (pop count 8) its head value is don't-care: the exhaustion
    // flag forces selection of the other run.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_exh[j]  = r_pop[j][3];
            w_head[j] = r_run[j][3'd7 - r_pop[j][2:0]];
        end
    end

    // Ties go to the higher-numbered run of the pair.
    assign w_sel_r1 = w_exh[0] | (~w_exh[1] & head_ge(w_head[1], w_head[0]));
    assign w_sel_r3 = w_exh[2] | (~w_exh[3] & head_ge(w_head[3], w_head[2]));
    assign w_pick_a = w_sel_r1 ? w_head[1] : w_head[0];
    assign w_pick_b = w_sel_r3 ? w_head[3] : w_head[2];

    assign w_accept = (r_state == S_IDLE) & ivalid;
    assign w_last   = (r_state == S_MERGE) & (r_cnt == 4'd15);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ivalid) w_state_nxt = S_MERGE;
            S_MERGE: if (r_cnt == 4'd15) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_ovalid <= 1'b0;
            r_lane_a <= '0;
            r_lane_b <= '0;
            for (int j = 0; j < 4; j++) begin
                r_pop[j] <= 4'd0;
                for (int k = 0; k < 8; k++) begin
                    r_run[j][k] <= '0;
                end
            end
        end else begin
            r_ovalid <= w_last;
            if (w_accept) begin
                // odata is left untouched here so the previous result stays
                // visible until the first merge edge of this frame.
                r_cnt <= 4'd0;
                for (int j = 0; j < 4; j++) begin
                    r_pop[j] <= 4'd0;
                    for (int k = 0; k < 8; k++) begin
                        r_run[j][k] <= idata[(j*8+k)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else if (r_state == S_MERGE) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_sel_r1) r_pop[1] <= r_pop[1] + 4'd1;
                else          r_pop[0] <= r_pop[0] + 4'd1;
                if (w_sel_r3) r_pop[3] <= r_pop[3] + 4'd1;
                else          r_pop[2] <= r_pop[2] + 4'd1;
                r_lane_a <= {r_lane_a[15*DATA_WIDTH-1:0], w_pick_a};
                r_lane_b <= {r_lane_b[15*DATA_WIDTH-1:0], w_pick_b};
            end
        end
    end

    assign iready = (r_state == S_IDLE);
    assign odata  = {r_lane_b, r_lane_a};
    assign ovalid = r_ovalid;

endmodule

// File: tb/tb_level_4_merge.sv
// Testbench for level_4_merge: accepted frames are pushed to a scoreboard
// with their expected result (sorted lane contents) and due cycle; a
// separate monitor pops and compares on every ovalid pulse.
module tb_level_4_merge;

    localparam int DW = 8;
    localparam int NE = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NE*DW-1:0]  idata;
    logic              ivalid;
    logic              iready;
    logic [NE*DW-1:0]  odata;
    logic              ovalid;

    level_4_merge #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .idata  (idata),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .ovalid (ovalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_pulse  = 0;

    typedef struct {
        int               due;
        logic [NE*DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic int key(input logic [DW-1:0] v);
`ifdef MERGE_L4_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    // Reference: each lane's result is simply its 16 elements sorted ascending.
    function automatic logic [NE*DW-1:0] model(input logic [NE*DW-1:0] d);
        logic [DW-1:0]    vals [16];
        logic [DW-1:0]    v;
        logic [NE*DW-1:0] res;
        int               j;
        res = '0;
        for (int lane = 0; lane < 2; lane++) begin
            for (int i = 0; i < 16; i++) vals[i] = d[(lane*16+i)*DW +: DW];
            for (int i = 1; i < 16; i++) begin
                v = vals[i];
                j = i - 1;
                while (j >= 0 && key(vals[j]) > key(v)) begin
                    vals[j+1] = vals[j];
                    j = j - 1;
                end
                vals[j+1] = v;
            end
            for (int i = 0; i < 16; i++) res[(lane*16+i)*DW +: DW] = vals[i];
        end
        return res;
    endfunction

    // Four independently random runs, each sorted ascending.
    function automatic logic [NE*DW-1:0] rand_frame();
        logic [DW-1:0]    r [8];
        logic [DW-1:0]    v;
        logic [NE*DW-1:0] f;
        int               j;
        f = '0;
        for (int run = 0; run < 4; run++) begin
            for (int i = 0; i < 8; i++) r[i] = DW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) r[3] = r[2];
            for (int i = 1; i < 8; i++) begin
                v = r[i];
                j = i - 1;
                while (j >= 0 && key(r[j]) > key(v)) begin
                    r[j+1] = r[j];
                    j = j - 1;
                end
                r[j+1] = v;
            end
            for (int i = 0; i < 8; i++) f[(run*8+i)*DW +: DW] = r[i];
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [NE*DW-1:0] act,
                         input logic [NE*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Acceptance monitor: a frame is taken on the edge ending a cycle with
    // ivalid && iready; its result must appear 17 cycles later.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ivalid && iready) begin
            e.due  = cyc + 17;
            e.data = model(idata);
            sb.push_back(e);
            n_acc++;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ovalid) begin
            n_pulse++;
            if (sb.size() == 0) begin
                check("spurious_ovalid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("odata", odata, e.data);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic send(input logic [NE*DW-1:0] f);
        int waited;
        waited = 0;
        while (!iready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!iready) check("iready_timeout", 0, 1);
        idata  = f;
        ivalid = 1'b1;
        @(posedge clk); #1;
        ivalid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NE*DW-1:0] f;
        int t0, acc0, pulse0;

        rst    = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_odata", odata, 0);
        check("reset_ovalid", ovalid, 0);
        check("reset_iready", iready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Interleaved runs: result is the identity ramp.
        for (int k = 0; k < 8; k++) begin
            f[(k)*DW    +: DW] = DW'(2*k+1);
            f[(8+k)*DW  +: DW] = DW'(2*k);
            f[(16+k)*DW +: DW] = DW'(2*k+17);
            f[(24+k)*DW +: DW] = DW'(2*k+16);
        end
        send(f);
        drain();

        // All equal: ties must pop the higher-numbered run first.
        f = {NE{8'h55}};
        send(f);
        @(posedge clk); #1;
        check("tie_pop_r0", dut.r_pop[0], 0);
        check("tie_pop_r1", dut.r_pop[1], 1);
        check("tie_pop_r2", dut.r_pop[2], 0);
        check("tie_pop_r3", dut.r_pop[3], 1);
        drain();

        // One run exhausts early; zeros are real data.
        f = '0;
        for (int k = 0; k < 8; k++) f[k*DW +: DW] = 8'hFF;
        send(f);
        drain();

        // Signed/unsigned boundary values.
        f = rand_frame();
        for (int k = 0; k < 8; k++) begin
            f[k*DW     +: DW] = 8'h7F;
            f[(8+k)*DW +: DW] = 8'h80;
        end
        send(f);
        drain();

        // ivalid held high for 60 cycles.
        t0     = cyc;
        acc0   = n_acc;
        pulse0 = n_pulse;
        ivalid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            idata = rand_frame();
            @(posedge clk); #1;
        end
        ivalid = 1'b0;
        check("held_accepts", n_acc - acc0, 4);
        check("held_pulses", n_pulse - pulse0, 3);
        drain();
        if (t0 < 0) check("held_t0", t0, 0);

        // Reset in merge cycle 8 aborts the frame.
        send(rand_frame());
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_odata", odata, 0);
        check("abort_ovalid", ovalid, 0);
        check("abort_iready", iready, 1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(rand_frame());
        drain();

        // Random frames with random gaps.
        for (int i = 0; i < 25; i++) begin
            send(rand_frame());
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
